// File: rtl/fpu_execute_ctrl.sv
`default_nettype none
// fpu_execute_ctrl: launches one decoded FP instruction on the shared arithmetic
// unit, watches it with a watchdog and emits a single-cycle register writeback.  Rev 1.0

module fpu_execute_ctrl #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] rl_in,
  input  logic [DSIZE-1:0] rr_in,
  input  logic [ASIZE-1:0] rd_addr_in,
  input  logic [3:0]       flags_in,
  output logic             fu_start,
  output logic [1:0]       fu_op,
  output logic [DSIZE-1:0] fu_a,
  output logic [DSIZE-1:0] fu_b,
  input  logic             fu_done,
  input  logic [DSIZE-1:0] fu_result,
  output logic             wb_valid,
  output logic [ASIZE-1:0] wb_addr,
  output logic [DSIZE-1:0] wb_data,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    wd_cnt;
  logic [ASIZE-1:0] rd_q;
  logic             accept;
  logic             flags_onehot;
  logic             flags_zero;
  logic [1:0]       op_enc;
  logic             timeout_hit;

  assign in_ready    = rst_n && ((state == S_IDLE) || (state == S_WB));
  assign accept      = in_valid && in_ready;
  assign flags_zero  = (flags_in == 4'b0000);
  assign timeout_hit = (state == S_WAIT) && !fu_done && (wd_cnt == CNT_LAST);

  always_comb begin
    flags_onehot = 1'b1;
    op_enc       = 2'b00;
    case (flags_in)
      4'b0001: op_enc = 2'b00;
      4'b0010: op_enc = 2'b01;
      4'b0100: op_enc = 2'b10;
      4'b1000: op_enc = 2'b11;
      default: flags_onehot = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && flags_onehot) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (fu_done) begin
          state_nxt = S_WB;
        end else if (wd_cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_WB:    state_nxt = (accept && flags_onehot) ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fu_start = (state == S_START);
    wb_valid = (state == S_WB);
    busy     = (state != S_IDLE);
  end

  // Destination is staged in rd_q so wb_addr only changes when a result is captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fu_a        <= '0;
      fu_b        <= '0;
      fu_op       <= 2'b00;
      rd_q        <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      wd_cnt      <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= accept && !flags_zero && !flags_onehot;
      err_timeout <= timeout_hit;
      if (accept && flags_onehot) begin
        fu_a  <= rl_in;
        fu_b  <= rr_in;
        fu_op <= op_enc;
        rd_q  <= rd_addr_in;
      end
      if (state == S_START) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !fu_done && !timeout_hit) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if ((state == S_WAIT) && fu_done) begin
        wb_data <= fu_result;
        wb_addr <= rd_q;
      end
    end
  end

endmodule

`default_nettype wire
